counter_rr_scheduler: RTL

Round-robin scheduler that shares one down-counting interval timer among NREQ requesters. Each requester asks for a timed interval of `period` ticks. The block arbitrates, loads the winner's period into the shared counter, and counts down on a clock-enable tick. It then returns a one-cycle done pulse to the winner. It sits between the free-running counter primitives and client blocks that need one-shot delays.

---
 rtl/counter_rr_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/counter_rr_scheduler.sv
// Round-robin scheduler sharing one down-counting interval timer among NREQ requesters.
// Latency: grant edge to done-high is period more ce edges (period=0: done with the grant).
// Backpressure: none; a grant holds until the interval ends or is aborted, others wait on req.
//
// Ports:
//   clk, clr       rising-edge clock, asynchronous active-high reset
//   req            level request per requester (bit i = requester i)
//   period         interval length per requester, slice i = [i*WIDTH +: WIDTH]
//   ce             count-enable tick; the counter only moves when ce=1
//   abort          cancel the running interval without a done pulse
//   gnt            registered one-hot grant
//   busy           high while an interval is in progress (COUNT or DONE)
//   cnt            registered counter value
//   done           registered one-cycle completion pulse to the granted requester
module counter_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] period,
    input  logic                  ce,
    input  logic                  abort,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      cnt,
    output logic [NREQ-1:0]       done
);

    localparam int PW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     idx_q, idx_d;

    logic              sel_vld;
    logic [PW-1:0]     sel_idx;
    logic [WIDTH-1:0]  sel_period;

    // Search upward from the requester after the last one served, wrapping,
    // so the most recently served requester has the lowest priority.
    always_comb begin : arb
        int j;
        j       = 0;
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr_q) + k) % NREQ;
            if (!sel_vld && req[j]) begin
                sel_vld = 1'b1;
                sel_idx = PW'(j);
            end
        end
    end

    assign sel_period = period[int'(sel_idx)*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    gnt_d = ONE << sel_idx;
                    idx_d = sel_idx;
                    cnt_d = sel_period;
                    if (sel_period == '0) begin
                        // Zero-length interval completes on the grant edge itself.
                        state_d = DONE;
                        done_d  = ONE << sel_idx;
                    end else begin
                        state_d = COUNT;
                    end
                end
            end
            COUNT: begin
                if (abort) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = idx_q;
                end else if (ce && cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == WIDTH'(1)) begin
                        state_d = DONE;
                        done_d  = gnt_q;
                    end
                end
            end
            DONE: begin
                // Abort is deliberately ignored here: the pulse is already out.
                state_d = IDLE;
                gnt_d   = '0;
                done_d  = '0;
                ptr_d   = idx_q;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                done_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= PW'(NREQ - 1);
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign cnt  = cnt_q;
    assign busy = (state_q != IDLE);

`ifndef SYNTHESIS
    a_gnt_onehot0:  assert property (@(posedge clk) disable iff (clr) $onehot0(gnt_q));
    a_done_onehot0: assert property (@(posedge clk) disable iff (clr) $onehot0(done_q));
    a_done_in_gnt:  assert property (@(posedge clk) disable iff (clr) (done_q & ~gnt_q) == '0);
    a_no_underflow: assert property (@(posedge clk) disable iff (clr) (state_q == COUNT) |-> (cnt_q != '0));
`endif

endmodule
